instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control FSM for the floating-point CPU. It steps each instruction through fetch, decode, execute and writeback, and owns the program counter. It hands operations to the variable-latency FP execute unit through a start/done handshake. It sits beside the register/control top and replaces ad-hoc stage enables with one registered state machine that also handles jump, halt, stall and execute timeout.

## Interface
- PC_W, 5, program counter width
- IMEM_DEPTH, 32, instruction memory depth; last valid address is IMEM_DEPTH-1
- EXEC_TIMEOUT, 64, maximum WAIT cycles before the error state

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- instr  in  59  instruction word: Imem[program_counter], combinational, valid in FETCH. Fields: flag[58:57], opcode[56:52], rd[51:47], rs1[46:42], rs2[41:37], pc[36:32], imm[31:0]
- stall  in  1  holds the FSM in FETCH while high
- exec_done  in  1  single-cycle pulse from the FP execute unit
- program_counter  out  PC_W  current instruction address
- fetch_stage_enable  out  1  high while in FETCH
- decode_stage_enable  out  1  high while in DECODE
- exec_start  out  1  one-cycle pulse in EXEC
- wb_enable  out  1  one-cycle pulse in WB; register-file write strobe
- flag_q, opcode_q, rd_q, rs1_q, rs2_q, imm_q  out  2/5/5/5/5/32  fields of the captured instruction
- halted  out  1  sticky; set in HALT or ERR
- timeout_err  out  1  sticky; set in ERR

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT, ERR.
- Stage outputs are Moore, decoded from the registered state.
- IDLE -> FETCH unconditionally on the first edge with rst low.
- FETCH:
  - stall=1: stay in FETCH; the instruction register is not loaded.
  - stall=0: load instr into the *_q registers, go to DECODE.
- DECODE:
  - flag=2'b11 and opcode=5'b11111: go to HALT.
  - flag=2'b10 (jump): program_counter <= imm_q[PC_W-1:0], go to FETCH. No exec_start, no wb_enable.
  - Otherwise (flag 00 register op, 01 immediate op): go to EXEC.
- EXEC: assert exec_start, clear the wait counter, go to WAIT.
- WAIT: exec_done is sampled only in this state; exec_done in EXEC is ignored.
  - exec_done=1: go to WB.
  - exec_done=0: increment the counter. When the counter reaches EXEC_TIMEOUT-1 without done, go to ERR.
- WB: assert wb_enable.
  - program_counter == IMEM_DEPTH-1: go to HALT; program_counter is unchanged.
  - Otherwise: program_counter +1, go to FETCH.
- HALT: halted=1. Stays until rst.
- ERR: halted=1, timeout_err=1. Stays until rst.
- The *_q outputs stay stable from DECODE through WB and are updated only on a FETCH capture.

## Timing
- Reset values, any state: state IDLE, program_counter 0, all enables 0, *_q 0, halted 0, timeout_err 0, wait counter 0.
- rst asserted mid-instruction (e.g. in WAIT) returns to IDLE on that edge. No wb_enable is issued for the aborted instruction.
- Cycle numbering: cycle 0 is the first cycle with rst low (state IDLE).
- Non-jump instruction with exec_done in the first WAIT cycle:
  - FETCH c1, DECODE c2, EXEC c3, WAIT c4, WB c5, next FETCH c6.
  - fetch_stage_enable rises every 5 cycles.
- Each extra exec latency cycle adds 1 cycle.
- Jump: FETCH, DECODE, then FETCH at the target (2 cycles per jump).
- program_counter updates on the WB->FETCH or DECODE->FETCH edge and is valid in the FETCH cycle.
- wb_enable coincides with the rd_q and imm_q values of the same instruction.

## Test plan
- Reset, then Imem[0]={00,00000,rd=3,rs1=1,rs2=2,pc=0,imm=0}, exec_done one cycle after exec_start -> fetch at c1, exec_start at c3, wb_enable at c5 with rd_q=3, program_counter=1 at c6.
- Imem[1]={10,00000,...,imm=3} (jump) -> no exec_start, program_counter=3 at the FETCH 2 cycles later.
- Imem[0]={11,11111,...} (halt) -> halted=1 from c3, fetch_stage_enable never reasserts.
- ADD with exec_done never asserted -> exactly 64 WAIT cycles, then timeout_err=1 and halted=1, no wb_enable.
- stall=1 for 3 cycles in FETCH -> fetch_stage_enable high for 4 cycles; capture uses the instr present on the release cycle. A second case with exec_done 10 cycles late -> wb_enable 10 cycles later than nominal.
- Execute an op at program_counter=31 -> wb_enable pulses, then halted=1 with program_counter=31. Separately, assert rst mid-WAIT -> IDLE next edge, all outputs at reset values, restart fetches Imem[0].

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch, decode,
// execute and writeback, owns the program counter and the FP execute handshake.
module instr_sequencer #(
  parameter int unsigned PC_W         = 5,
  parameter int unsigned IMEM_DEPTH   = 32,
  parameter int unsigned EXEC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [58:0]     instr,
  input  logic            stall,
  input  logic            exec_done,
  output logic [PC_W-1:0] program_counter,
  output logic            fetch_stage_enable,
  output logic            decode_stage_enable,
  output logic            exec_start,
  output logic            wb_enable,
  output logic [1:0]      flag_q,
  output logic [4:0]      opcode_q,
  output logic [4:0]      rd_q,
  output logic [4:0]      rs1_q,
  output logic [4:0]      rs2_q,
  output logic [31:0]     imm_q,
  output logic            halted,
  output logic            timeout_err
);

  localparam int unsigned CNT_W = (EXEC_TIMEOUT > 2) ? $clog2(EXEC_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALT, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       flag_d;
  logic [4:0]       opcode_d, rd_d, rs1_d, rs2_d;
  logic [31:0]      imm_d;
  logic             fetch_en_q, fetch_en_d;
  logic             dec_en_q, dec_en_d;
  logic             exec_start_q, exec_start_d;
  logic             wb_en_q, wb_en_d;
  logic             halted_q, halted_d;
  logic             tmo_q, tmo_d;

  // The embedded pc field of the instruction word has no role in sequencing.
  logic unused_pc_field;
  assign unused_pc_field = ^instr[36:32];

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (!stall) begin
          flag_d   = instr[58:57];
          opcode_d = instr[56:52];
          rd_d     = instr[51:47];
          rs1_d    = instr[46:42];
          rs2_d    = instr[41:37];
          imm_d    = instr[31:0];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (flag_q == 2'b11 && opcode_q == 5'b11111) begin
          state_d = S_HALT;
        end else if (flag_q == 2'b10) begin
          pc_d    = imm_q[PC_W-1:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_W'(EXEC_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        if (pc_q == PC_W'(IMEM_DEPTH - 1)) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the decode of the state being entered.
    fetch_en_d   = (state_d == S_FETCH);
    dec_en_d     = (state_d == S_DECODE);
    exec_start_d = (state_d == S_EXEC);
    wb_en_d      = (state_d == S_WB);
    halted_d     = halted_q | (state_d == S_HALT) | (state_d == S_ERR);
    tmo_d        = tmo_q | (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      cnt_q        <= '0;
      flag_q       <= '0;
      opcode_q     <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      fetch_en_q   <= 1'b0;
      dec_en_q     <= 1'b0;
      exec_start_q <= 1'b0;
      wb_en_q      <= 1'b0;
      halted_q     <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      fetch_en_q   <= fetch_en_d;
      dec_en_q     <= dec_en_d;
      exec_start_q <= exec_start_d;
      wb_en_q      <= wb_en_d;
      halted_q     <= halted_d;
      tmo_q        <= tmo_d;
    end
  end

  assign program_counter     = pc_q;
  assign fetch_stage_enable  = fetch_en_q;
  assign decode_stage_enable = dec_en_q;
  assign exec_start          = exec_start_q;
  assign wb_enable           = wb_en_q;
  assign halted              = halted_q;
  assign timeout_err         = tmo_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: builds the expected per-cycle timeline of each program
// from instruction-level rules, then replays the planned stimulus and compares.
module tb_instr_sequencer;

  localparam int unsigned CAP = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        exec_done;
  logic [58:0] instr;
  logic [4:0]  program_counter;
  logic        fetch_stage_enable, decode_stage_enable, exec_start, wb_enable;
  logic [1:0]  flag_q;
  logic [4:0]  opcode_q, rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q;
  logic        halted, timeout_err;

  logic [58:0] imem [32];
  logic [58:0] noise;

  always #5 clk = ~clk;

  // Garbage on instr while stalled: only the release-cycle word may be captured.
  assign instr = stall ? noise : imem[program_counter];

  instr_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .stall(stall), .exec_done(exec_done),
    .program_counter(program_counter), .fetch_stage_enable(fetch_stage_enable),
    .decode_stage_enable(decode_stage_enable), .exec_start(exec_start),
    .wb_enable(wb_enable), .flag_q(flag_q), .opcode_q(opcode_q), .rd_q(rd_q),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .imm_q(imm_q), .halted(halted),
    .timeout_err(timeout_err)
  );

  logic [5:0]  ctl_obs;
  logic [53:0] fld_obs;
  assign ctl_obs = {fetch_stage_enable, decode_stage_enable, exec_start, wb_enable,
                    halted, timeout_err};
  assign fld_obs = {flag_q, opcode_q, rd_q, rs1_q, rs2_q, imm_q};

  typedef struct {
    logic [5:0]  ctl;
    logic [4:0]  pc;
    logic [53:0] fld;
    logic        stall;
    logic        done;
    logic        rst;
  } cyc_t;

  cyc_t        exp_q[$];
  int          stall_plan[$];
  int          lat_plan[$];
  int          rst_instr;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [4:0]  mpc;
  logic [53:0] mfld;

  localparam logic [5:0] C_IDLE = 6'b000000, C_FETCH = 6'b100000, C_DEC = 6'b010000,
                         C_EXEC = 6'b001000, C_WAIT = 6'b000000, C_WB = 6'b000100,
                         C_HALT = 6'b000010, C_ERR = 6'b000011;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [58:0] mk(input logic [1:0] f, input logic [4:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm);
    return {f, op, rd, rs1, rs2, 5'(31 - rd), imm};
  endfunction

  function automatic logic [58:0] rand_word();
    int r;
    logic [1:0] f;
    logic [4:0] op;
    r = int'($urandom_range(0, 99));
    op = 5'($urandom);
    if (r < 8) return mk(2'b11, 5'b11111, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    if (r < 30) return mk(2'b10, op, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    f = (r < 40) ? 2'b11 : 2'($urandom_range(0, 1));
    if (f == 2'b11 && op == 5'b11111) op = 5'b00001;
    return mk(f, op, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
  endfunction

  task automatic add(input logic [5:0] ctl, input logic st, input logic dn, input logic rs);
    cyc_t e;
    e.ctl = ctl; e.pc = mpc; e.fld = mfld; e.stall = st; e.done = dn; e.rst = rs;
    exp_q.push_back(e);
  endtask

  // Expected timeline from instruction-level rules: each FETCH lasts 1+stall cycles,
  // jumps cost 2 cycles, ops cost 5+latency cycles, halt/timeout/last-address end the run.
  task automatic build();
    int s, l, n_instr;
    bit stop;
    logic [58:0] w;
    exp_q.delete();
    mpc = '0; mfld = '0; n_instr = 0; stop = 0;
    add(C_IDLE, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    while (!stop && exp_q.size() < CAP) begin
      s = (stall_plan.size() != 0) ? stall_plan.pop_front()
          : (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
      repeat (s) add(C_FETCH, 1'b1, 1'b0, 1'b0);
      add(C_FETCH, 1'b0, 1'b0, 1'b0);
      w = imem[mpc];
      mfld = {w[58:37], w[31:0]};
      add(C_DEC, 1'b0, 1'b0, 1'b0);
      if (w[58:57] == 2'b11 && w[56:52] == 5'b11111) begin
        repeat (4) add(C_HALT, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        stop = 1;
      end else if (w[58:57] == 2'b10) begin
        mpc = w[4:0];
      end else begin
        if (lat_plan.size() != 0) l = lat_plan.pop_front();
        else l = ($urandom_range(0, 99) < 3) ? -1 : int'($urandom_range(0, 6));
        add(C_EXEC, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (l < 0) begin
          repeat (64) add(C_WAIT, 1'b0, 1'b0, 1'b0);
          repeat (4) add(C_ERR, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
          stop = 1;
        end else if (n_instr == rst_instr && l >= 1) begin
          add(C_WAIT, 1'b0, 1'b0, 1'b1);
          mpc = '0; mfld = '0; rst_instr = -1;
          add(C_IDLE, 1'b0, 1'b0, 1'b0);
        end else begin
          repeat (l) add(C_WAIT, 1'b0, 1'b0, 1'b0);
          add(C_WAIT, 1'b0, 1'b1, 1'b0);
          add(C_WB, 1'b0, 1'b0, 1'b0);
          if (mpc == 5'd31) begin
            repeat (4) add(C_HALT, 1'b0, 1'b0, 1'b0);
            stop = 1;
          end else begin
            mpc = mpc + 5'd1;
          end
        end
      end
      n_instr++;
    end
  endtask

  task automatic run_episode();
    cyc_t e;
    build();
    rst = 1'b1; stall = 1'b0; exec_done = 1'b0;
    @(posedge clk); #1;
    chk("reset_ctl", 64'(ctl_obs), 64'(0));
    chk("reset_pc", 64'(program_counter), 64'(0));
    chk("reset_fields", 64'(fld_obs), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ctl", 64'(ctl_obs), 64'(e.ctl));
      chk("pc", 64'(program_counter), 64'(e.pc));
      chk("fields", 64'(fld_obs), 64'(e.fld));
      stall = e.stall; exec_done = e.done; rst = e.rst;
      noise = 59'({$urandom, $urandom});
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 32; i++) imem[i] = mk(2'b11, 5'b11111, 5'd0, 5'd0, 5'd0, 32'd0);
    stall_plan.delete(); lat_plan.delete(); rst_instr = -1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; exec_done = 1'b0; noise = '0;
    for (int i = 0; i < 32; i++) imem[i] = '0;

    // Op, jump to 3, halt: nominal 5-cycle op and 2-cycle jump.
    fill_halt();
    imem[0] = mk(2'b00, 5'b00000, 5'd3, 5'd1, 5'd2, 32'd0);
    imem[1] = mk(2'b10, 5'b00000, 5'd0, 5'd0, 5'd0, 32'd3);
    stall_plan = '{0, 0, 0}; lat_plan = '{0};
    run_episode();

    // Halt at address 0.
    fill_halt();
    stall_plan = '{0};
    run_episode();

    // Execute unit never answers.
    fill_halt();
    imem[0] = mk(2'b00, 5'b00001, 5'd7, 5'd1, 5'd2, 32'h1234);
    stall_plan = '{0}; lat_plan = '{-1};
    run_episode();

    // Three stall cycles, then done ten cycles late.
    fill_halt();
    imem[0] = mk(2'b01, 5'b00010, 5'd9, 5'd4, 5'd5, 32'hdeadbeef);
    stall_plan = '{3, 0}; lat_plan = '{10};
    run_episode();

    // Op at the last address halts after writeback.
    fill_halt();
    imem[0]  = mk(2'b10, 5'b00000, 5'd0, 5'd0, 5'd0, 32'hffff_ff1f);
    imem[31] = mk(2'b00, 5'b00011, 5'd12, 5'd6, 5'd8, 32'h55);
    stall_plan = '{0, 0}; lat_plan = '{2};
    run_episode();

    // Reset mid-WAIT, then restart from address 0.
    fill_halt();
    imem[0] = mk(2'b00, 5'b00100, 5'd5, 5'd1, 5'd1, 32'h77);
    stall_plan = '{0, 0, 0}; lat_plan = '{5, 1}; rst_instr = 0;
    run_episode();

    // Random programs.
    for (int ep = 0; ep < 10; ep++) begin
      fill_halt();
      for (int i = 0; i < 32; i++) imem[i] = rand_word();
      rst_instr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_episode();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
